catc_delay_arbiter: RTL

//   Shares one long-latency resource (e.g. an SDRAM port) between NumReq requesters and drives
//   the Delay input of the RetroCATC instance while an access is in flight. Tracks stall debt in

---
 rtl/catc_delay_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/catc_delay_arbiter.sv
// Round-robin arbiter for one shared long-latency resource. Drives RetroCATC Delay
// while an access is in flight, tracks stall debt and throttles non-urgent grants.
module catc_delay_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned DebtBits = 16,
    parameter int unsigned MaxDebt  = 1024,
    parameter int unsigned LowWater = 256,
    parameter int unsigned MaxBusy  = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ref_tick,
    input  logic                        i_catch_up_tick,
    input  logic [NumReq-1:0]           i_req,
    input  logic [NumReq-1:0]           i_urgent,
    input  logic                        i_done,
    input  logic                        i_timeout_clr,
    output logic [NumReq-1:0]           o_gnt,
    output logic                        o_start,
    output logic                        o_delay,
    output logic [DebtBits-1:0]         o_debt,
    output logic                        o_throttled,
    output logic                        o_timeout,
    output logic [$clog2(NumReq)-1:0]   o_timeout_id
);

    localparam int unsigned IdW   = $clog2(NumReq);
    localparam int unsigned BusyW = $clog2(MaxBusy);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IdW-1:0]        r_ptr;
    logic [IdW-1:0]        w_ptr_nxt;
    logic [BusyW-1:0]      r_busy_cnt;
    logic [BusyW-1:0]      w_busy_cnt_nxt;
    logic [NumReq-1:0]     r_gnt;
    logic [NumReq-1:0]     w_gnt_nxt;
    logic                  r_start;
    logic                  w_start_nxt;
    logic                  r_delay;
    logic [DebtBits-1:0]   r_debt;
    logic [DebtBits-1:0]   w_debt_nxt;
    logic                  r_throttled;
    logic                  w_throttled_nxt;
    logic                  r_timeout;
    logic [IdW-1:0]        r_timeout_id;
    logic                  w_timeout_set;
    logic [NumReq-1:0]     w_elig;
    logic                  w_found;
    logic [IdW-1:0]        w_pick;
    logic                  w_inc;
    logic                  w_dec;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_elig  = i_req & (r_throttled ? i_urgent : {NumReq{1'b1}});
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            if (!w_found && w_elig[IdW'((32'(r_ptr) + k) % NumReq)]) begin
                w_found = 1'b1;
                w_pick  = IdW'((32'(r_ptr) + k) % NumReq);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_busy_cnt_nxt = r_busy_cnt;
        w_gnt_nxt      = r_gnt;
        w_start_nxt    = 1'b0;
        w_timeout_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_BUSY;
                    w_ptr_nxt      = w_pick;
                    w_busy_cnt_nxt = '0;
                    w_gnt_nxt      = NumReq'(1) << w_pick;
                    w_start_nxt    = 1'b1;
                end
            end
            S_BUSY: begin
                if (i_done) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end else if (r_busy_cnt == BusyW'(MaxBusy - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_gnt_nxt     = '0;
                    w_timeout_set = 1'b1;
                end else begin
                    w_busy_cnt_nxt = r_busy_cnt + BusyW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // Debt moves only when exactly one of accrue/repay is active; saturates both ends
    always_comb begin
        w_inc      = r_delay & i_ref_tick;
        w_dec      = i_catch_up_tick;
        w_debt_nxt = r_debt;
        if (w_inc && !w_dec && (r_debt != {DebtBits{1'b1}})) begin
            w_debt_nxt = r_debt + DebtBits'(1);
        end else if (w_dec && !w_inc && (r_debt != '0)) begin
            w_debt_nxt = r_debt - DebtBits'(1);
        end
        w_throttled_nxt = r_throttled;
        if (32'(r_debt) >= MaxDebt) begin
            w_throttled_nxt = 1'b1;
        end else if (32'(r_debt) < LowWater) begin
            w_throttled_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= IdW'(NumReq - 1);
            r_busy_cnt   <= '0;
            r_gnt        <= '0;
            r_start      <= 1'b0;
            r_delay      <= 1'b0;
            r_debt       <= '0;
            r_throttled  <= 1'b0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_busy_cnt  <= w_busy_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_start     <= w_start_nxt;
            r_delay     <= (w_state_nxt == S_BUSY);
            r_debt      <= w_debt_nxt;
            r_throttled <= w_throttled_nxt;
            if (w_timeout_set) begin
                r_timeout    <= 1'b1;
                r_timeout_id <= r_ptr;
            end else if (i_timeout_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign o_gnt        = r_gnt;
    assign o_start      = r_start;
    assign o_delay      = r_delay;
    assign o_debt       = r_debt;
    assign o_throttled  = r_throttled;
    assign o_timeout    = r_timeout;
    assign o_timeout_id = r_timeout_id;

endmodule
